// File: rtl/lzrw_pkg.sv
// Shared definitions for the LZRW1 compressor / decompressor pair.
//   HISTSIZE  : sliding-window depth in bytes (matches the compressor window)
//   OFFW/LENW : field widths of a copy item
//   MIN_MATCH : shortest copy; the encoded length is stored minus this value
//   dec_state_t : decompressor FSM states
//   lzrw_item_t : one compressed item as it travels between the two ends
package lzrw_pkg;

    localparam int HISTSIZE  = 4096;
    localparam int OFFW      = 12;
    localparam int LENW      = 4;
    localparam int MIN_MATCH = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DONE
    } dec_state_t;

    // The literal field is called "lit" because "byte" is a reserved word.
    typedef struct packed {
        logic            ctrl;
        logic [7:0]      lit;
        logic [OFFW-1:0] offset;
        logic [LENW-1:0] len;
        logic            last;
    } lzrw_item_t;

endpackage

// File: rtl/lzrw1_decompressor_history.sv
// History buffer for the LZRW1 decompressor.
//   clock         : write clock
//   wrEn/wrAddr/wrData : synchronous write port
//   rdAddr/rdData : asynchronous read port (combinational, 0-cycle latency)
// The contents are never cleared; the owner tracks how much is valid.
module dec_history #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];

    // Single write port; bytes become readable on the cycle after they land.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Combinational read so a copy can fetch and re-emit a byte in one cycle.
    assign rdData = mem[rdAddr];

endmodule

// File: rtl/lzrw1_decompressor.sv
// Streaming LZRW1 decompressor.
// Takes one item per handshake (literal byte or offset/length copy), rebuilds
// the original stream in a sliding history and emits one byte per cycle.
//   clock, reset                 : clock, asynchronous active-high reset
//   in_valid/in_ready            : item handshake
//   in_ctrl/in_byte/in_offset/in_len/in_last : item fields (copy length = in_len+3)
//   out_valid/out_ready/out_byte : reconstructed byte stream
//   byte_count                   : bytes written into history since reset (wraps)
//   err                          : sticky, an item carried an unreachable offset
//   done                         : sticky, last byte of the final item was consumed
module lzrw1_decompressor
    import lzrw_pkg::dec_state_t;
    import lzrw_pkg::S_IDLE;
    import lzrw_pkg::S_COPY;
    import lzrw_pkg::S_DONE;
    import lzrw_pkg::lzrw_item_t;
    import lzrw_pkg::MIN_MATCH;
#(
    parameter int HISTSIZE = lzrw_pkg::HISTSIZE,
    parameter int COUNTW   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ctrl,
    input  logic [7:0]        in_byte,
    input  logic [11:0]       in_offset,
    input  logic [3:0]        in_len,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic [COUNTW-1:0] byte_count,
    output logic              err,
    output logic              done
);

    localparam int AW    = $clog2(HISTSIZE);
    localparam int FILLW = AW + 1;

    dec_state_t        state;
    dec_state_t        nextState;
    lzrw_item_t        item;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     rdAddr;
    logic [FILLW-1:0]  fill;
    logic [4:0]        remaining;
    logic              outValid;
    logic [7:0]        outByte;
    logic [COUNTW-1:0] byteCount;
    logic              errFlag;
    logic              doneFlag;
    logic              lastPending;
    logic              adv;
    logic              accept;
    logic              badOffset;
    logic              emit;
    logic [7:0]        wrData;
    logic [7:0]        rdData;

    assign item = '{ctrl: in_ctrl, lit: in_byte, offset: in_offset, len: in_len, last: in_last};

    // The output register can take a new byte when empty or being drained.
    assign adv = !outValid || out_ready;

    // Once the final item is in, no further items are taken, so the byte
    // waiting in the output register can only be the last one.
    assign in_ready  = (state == S_IDLE) && adv && !doneFlag && !lastPending && !reset;
    assign accept    = in_valid && in_ready;
    assign badOffset = (item.offset == '0) || (FILLW'(item.offset) > fill);

    // While idle the read port looks at the copy source of the incoming item
    // so the first copy byte goes out on the accepting edge.
    assign rdAddr = (state == S_COPY) ? rptr : (wptr - AW'(item.offset));

    dec_history #(
        .DEPTH (HISTSIZE),
        .AW    (AW)
    ) uHistory (
        .clock  (clock),
        .wrEn   (emit),
        .wrAddr (wptr),
        .wrData (wrData),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and the per-cycle "emit a byte" decision.
    always_comb begin
        nextState = state;
        emit      = 1'b0;
        wrData    = rdData;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!item.ctrl) begin
                        emit   = 1'b1;
                        wrData = item.lit;
                    end else if (!badOffset) begin
                        emit      = 1'b1;
                        nextState = S_COPY;
                    end else if (item.last) begin
                        nextState = S_DONE;
                    end
                end else if (lastPending && outValid && out_ready) begin
                    nextState = S_DONE;
                end
            end
            S_COPY: begin
                if (adv) begin
                    emit = 1'b1;
                    if (remaining == 5'd1) begin
                        nextState = S_IDLE;
                    end
                end
            end
            default: begin
                nextState = state;
            end
        endcase
    end

    // Datapath: pointers, counters, output register and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            fill        <= '0;
            remaining   <= '0;
            outValid    <= 1'b0;
            outByte     <= '0;
            byteCount   <= '0;
            errFlag     <= 1'b0;
            doneFlag    <= 1'b0;
            lastPending <= 1'b0;
        end else begin
            if (outValid && out_ready) begin
                outValid <= 1'b0;
            end
            if (emit) begin
                outValid  <= 1'b1;
                outByte   <= wrData;
                wptr      <= wptr + AW'(1);
                byteCount <= byteCount + COUNTW'(1);
                if (fill != FILLW'(HISTSIZE)) begin
                    fill <= fill + FILLW'(1);
                end
            end
            if (accept) begin
                lastPending <= item.last;
                if (item.ctrl) begin
                    if (badOffset) begin
                        errFlag <= 1'b1;
                    end else begin
                        rptr      <= rdAddr + AW'(1);
                        remaining <= 5'(item.len) + 5'(MIN_MATCH - 1);
                    end
                end
            end
            if (state == S_COPY && emit) begin
                rptr      <= rptr + AW'(1);
                remaining <= remaining - 5'd1;
            end
            if (nextState == S_DONE && state != S_DONE) begin
                doneFlag <= 1'b1;
            end
        end
    end

    assign out_valid  = outValid;
    assign out_byte   = outByte;
    assign byte_count = byteCount;
    assign err        = errFlag;
    assign done       = doneFlag;

endmodule
